// File: rtl/shift_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer: frames start on srl_sof, completed words
// are held in an output register under a valid/ready handshake.
module shift_deser
    import shift_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srl_en,
    input  logic             srl_in,
    input  logic             srl_sof,
    input  logic             prl_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] prl_out,
    output logic             prl_valid,
    output logic             busy,
    output logic             ovr_err,
    output logic             frm_err
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t           state, state_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] shifted, first_word;
    logic             word_done, frm_set;
    logic             load, drop, consume;

    // shifted: register with the incoming bit appended; first_word: fresh frame.
    always_comb begin
        first_word = '0;
        if (MSB_FIRST) begin
            shifted       = {shreg[WIDTH-2:0], srl_in};
            first_word[0] = srl_in;
        end else begin
            shifted             = {srl_in, shreg[WIDTH-1:1]};
            first_word[WIDTH-1] = srl_in;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        shreg_n   = shreg;
        word_done = 1'b0;
        frm_set   = 1'b0;
        case (state)
            IDLE: begin
                if (srl_en && srl_sof) begin
                    shreg_n = first_word;
                    count_n = ONE;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (srl_en) begin
                    if (srl_sof) begin
                        // A new frame start always wins, even on the final bit.
                        frm_set = 1'b1;
                        shreg_n = first_word;
                        count_n = ONE;
                    end else if (count == LAST) begin
                        word_done = 1'b1;
                        shreg_n   = shifted;
                        count_n   = '0;
                        state_n   = IDLE;
                    end else begin
                        shreg_n = shifted;
                        count_n = count + ONE;
                    end
                end
            end
        endcase
    end

    assign consume = prl_valid && prl_ready;
    assign load    = word_done && (!prl_valid || prl_ready);
    assign drop    = word_done && prl_valid && !prl_ready;
    assign busy    = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            shreg <= shreg_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prl_out   <= '0;
            prl_valid <= 1'b0;
        end else begin
            if (load) begin
                prl_out <= shifted;
            end
            if (load) begin
                prl_valid <= 1'b1;
            end else if (consume) begin
                prl_valid <= 1'b0;
            end
        end
    end

    // Set events take priority over err_clr on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            if (drop) begin
                ovr_err <= 1'b1;
            end else if (err_clr) begin
                ovr_err <= 1'b0;
            end
            if (frm_set) begin
                frm_err <= 1'b1;
            end else if (err_clr) begin
                frm_err <= 1'b0;
            end
        end
    end

endmodule
